// File: rtl/dm_arbiter.sv
// Data-memory arbiter: the CPU and a DMA/debug port share one single-cycle-read memory port.
// Define DM_ARB_STATS_EN to add the saturating stall_cnt / dma_cnt statistics outputs.
module dm_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_done,
  output logic [31:0] dma_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
`ifdef DM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] dma_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_WAIT = 2'd1,
    DMA_WAIT = 2'd2
  } state_t;

  localparam int            SW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic          in_idle;
  logic          starve_hit;
  logic          cpu_win;
  logic          dma_win;

  // Every output is qualified by Reset so the block is silent while reset is held,
  // independent of the (asynchronously cleared) state register.
  assign in_idle    = Reset && (state == IDLE);
  assign starve_hit = (starve_cnt == LIMIT);
  assign dma_win    = in_idle && dma_req && (!cpu_req || starve_hit);
  assign cpu_win    = in_idle && cpu_req && !dma_win;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_win) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_win) begin
      mem_en    = 1'b1;
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  assign dma_gnt   = dma_win;
  assign cpu_stall = Reset && cpu_req && (state != CPU_WAIT);
  assign dma_done  = Reset && (state == DMA_WAIT);
  assign cpu_rdata = (Reset && (state == CPU_WAIT)) ? mem_rdata : '0;
  assign dma_rdata = dma_done ? mem_rdata : '0;

  // NOTE: state is cleared asynchronously and updated with non-blocking assignments only,
  // so every register samples the pre-edge values of its neighbours.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_win)      state <= CPU_WAIT;
          else if (dma_win) state <= DMA_WAIT;
        end
        CPU_WAIT: state <= IDLE;
        DMA_WAIT: state <= IDLE;
        default:  state <= IDLE;
      endcase

      // The counter tracks arbitrations the waiting DMA has lost to the CPU;
      // it holds through the WAIT cycles and forgets everything once the DMA gives up or wins.
      if (!dma_req || dma_win) begin
        starve_cnt <= '0;
      end else if (in_idle && !starve_hit) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

`ifdef DM_ARB_STATS_EN
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      stall_cnt <= '0;
      dma_cnt   <= '0;
    end else begin
      if (cpu_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (dma_gnt && (dma_cnt != '1))     dma_cnt   <= dma_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: read data is scoreboarded against a reference memory,
// handshake and arbitration timing are checked cycle by cycle.
module tb_dm_arbiter;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_done;
  logic [31:0] dma_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
`ifdef DM_ARB_STATS_EN
  logic [15:0] stall_cnt, dma_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [int];
  logic [31:0] cpu_q [$];
  logic [31:0] dma_q [$];
  logic [31:0] mon_exp;

  always #5 CLK = ~CLK;

  dm_arbiter #(.STARVE_LIMIT(4), .CNT_W(16)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_stall (cpu_stall),
    .cpu_rdata (cpu_rdata),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_gnt   (dma_gnt),
    .dma_done  (dma_done),
    .dma_rdata (dma_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef DM_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .dma_cnt   (dma_cnt)
`endif
  );

  // Synchronous memory: read data appears the cycle after the command, writes return zero.
  always @(posedge CLK) begin
    if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= (mem_en && !mem_we) ? mem[mem_addr[9:2]] : 32'h0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Completion monitor: pops the scoreboard whenever a requester receives its data.
  always @(negedge CLK) begin
    if (Reset && cpu_req && !cpu_stall) begin
      if (cpu_q.size() == 0) check("cpu_unexpected_done", 32'(cpu_q.size()), 32'd1);
      else begin
        mon_exp = cpu_q.pop_front();
        check("cpu_rdata", cpu_rdata, mon_exp);
      end
    end
    if (Reset && dma_done) begin
      if (dma_q.size() == 0) check("dma_unexpected_done", 32'(dma_q.size()), 32'd1);
      else begin
        mon_exp = dma_q.pop_front();
        check("dma_rdata", dma_rdata, mon_exp);
      end
    end
  end

  task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge CLK); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    if (we) begin
      ref_mem[int'(addr)] = wdata;
      cpu_q.push_back(32'h0);
    end else begin
      cpu_q.push_back(ref_mem[int'(addr)]);
    end
    @(negedge CLK);
    check("cpu_c0_stall", {31'b0, cpu_stall}, 32'd1);
    check("cpu_c0_mem_en", {31'b0, mem_en}, 32'd1);
    check("cpu_c0_mem_we", {31'b0, mem_we}, {31'b0, we});
    check("cpu_c0_mem_addr", mem_addr, addr);
    if (we) check("cpu_c0_mem_wdata", mem_wdata, wdata);
    check("cpu_c0_rdata_zero", cpu_rdata, 32'h0);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("cpu_c1_stall", {31'b0, cpu_stall}, 32'd0);
    check("cpu_c1_mem_en", {31'b0, mem_en}, 32'd0);
    @(posedge CLK); #1;
    cpu_req = 1'b0;
  endtask

  task automatic dma_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge CLK); #1;
    dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
    if (we) begin
      ref_mem[int'(addr)] = wdata;
      dma_q.push_back(32'h0);
    end else begin
      dma_q.push_back(ref_mem[int'(addr)]);
    end
    @(negedge CLK);
    check("dma_c0_gnt", {31'b0, dma_gnt}, 32'd1);
    check("dma_c0_done", {31'b0, dma_done}, 32'd0);
    check("dma_c0_mem_en", {31'b0, mem_en}, 32'd1);
    check("dma_c0_mem_we", {31'b0, mem_we}, {31'b0, we});
    check("dma_c0_mem_addr", mem_addr, addr);
    if (we) check("dma_c0_mem_wdata", mem_wdata, wdata);
    check("dma_c0_rdata_zero", dma_rdata, 32'h0);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("dma_c1_gnt", {31'b0, dma_gnt}, 32'd0);
    check("dma_c1_done", {31'b0, dma_done}, 32'd1);
    check("dma_c1_mem_en", {31'b0, mem_en}, 32'd0);
    @(posedge CLK); #1;
    dma_req = 1'b0;
  endtask

  // CPU hammers address 0x10 while the DMA waits on 0x20: with a limit of 4 the CPU
  // takes the IDLE cycles 0,2,4,6, the DMA is granted in cycle 8 and the CPU returns in cycle 10.
  task automatic contend();
    for (int c = 0; c < 12; c++) begin
      @(posedge CLK); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
      dma_req = (c <= 9); dma_we = 1'b0; dma_addr = 32'h20;
      if (c == 0 || c == 2 || c == 4 || c == 6 || c == 10) cpu_q.push_back(ref_mem[32'h10]);
      if (c == 8) dma_q.push_back(ref_mem[32'h20]);
      @(negedge CLK);
      check($sformatf("cont_c%0d_gnt", c), {31'b0, dma_gnt}, {31'b0, (c == 8)});
      check($sformatf("cont_c%0d_stall", c), {31'b0, cpu_stall},
            {31'b0, !(c[0] && c != 9)});
      check($sformatf("cont_c%0d_mem_en", c), {31'b0, mem_en}, {31'b0, !c[0]});
    end
    @(posedge CLK); #1;
    cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  // A one-cycle DMA request during CPU_WAIT must vanish without an access or any starvation credit.
  task automatic dma_pulse();
    @(posedge CLK); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    cpu_q.push_back(ref_mem[32'h10]);
    @(negedge CLK);
    check("pulse_c0_stall", {31'b0, cpu_stall}, 32'd1);
    @(posedge CLK); #1;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h24;
    @(negedge CLK);
    check("pulse_c1_gnt", {31'b0, dma_gnt}, 32'd0);
    check("pulse_c1_mem_en", {31'b0, mem_en}, 32'd0);
    @(posedge CLK); #1;
    dma_req = 1'b0; cpu_req = 1'b0;
    @(negedge CLK);
    check("pulse_c2_gnt", {31'b0, dma_gnt}, 32'd0);
    check("pulse_c2_mem_en", {31'b0, mem_en}, 32'd0);
  endtask

  task automatic reset_mid_dma();
    @(posedge CLK); #1;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h10;
    @(negedge CLK);
    check("rst_c0_gnt", {31'b0, dma_gnt}, 32'd1);
    @(posedge CLK); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    #1 Reset = 1'b0;
    #1;
    check("rst_now_done", {31'b0, dma_done}, 32'd0);
    check("rst_now_dma_rdata", dma_rdata, 32'h0);
    check("rst_now_stall", {31'b0, cpu_stall}, 32'd0);
    check("rst_now_mem_en", {31'b0, mem_en}, 32'd0);
    check("rst_now_gnt", {31'b0, dma_gnt}, 32'd0);
    @(negedge CLK);
    check("rst_neg_done", {31'b0, dma_done}, 32'd0);
    @(posedge CLK); #1;
    Reset = 1'b1; dma_req = 1'b0;
    cpu_q.push_back(ref_mem[32'h10]);
    @(negedge CLK);
    check("rst_rel_c0_stall", {31'b0, cpu_stall}, 32'd1);
    check("rst_rel_c0_mem_en", {31'b0, mem_en}, 32'd1);
    check("rst_rel_c0_done", {31'b0, dma_done}, 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("rst_rel_c1_stall", {31'b0, cpu_stall}, 32'd0);
    @(posedge CLK); #1;
    cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hFFFF_FFFC; cpu_wdata = 32'hA5A5_A5A5;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0000_0FF0; dma_wdata = 32'h5A5A_5A5A;
    #3;
    check("reset_stall", {31'b0, cpu_stall}, 32'd0);
    check("reset_mem_en", {31'b0, mem_en}, 32'd0);
    check("reset_mem_we", {31'b0, mem_we}, 32'd0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    check("reset_gnt", {31'b0, dma_gnt}, 32'd0);
    check("reset_done", {31'b0, dma_done}, 32'd0);
    check("reset_cpu_rdata", cpu_rdata, 32'h0);
    check("reset_dma_rdata", dma_rdata, 32'h0);
    #20;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
    @(posedge CLK); #1;
    Reset = 1'b1;

    dma_op(1'b1, 32'h10, 32'hDEAD_BEEF);
    cpu_op(1'b0, 32'h10, 32'h0);
    dma_op(1'b1, 32'h20, 32'h0000_1234);
    check("mem_word_0x20", mem[8], 32'h0000_1234);
    dma_op(1'b0, 32'h20, 32'h0);

    contend();
    dma_pulse();
    contend();
    reset_mid_dma();

    @(posedge CLK); #1;
    Reset = 1'b0;
    #2;
`ifdef DM_ARB_STATS_EN
    check("stats_reset_stall", {16'b0, stall_cnt}, 32'd0);
    check("stats_reset_dma", {16'b0, dma_cnt}, 32'd0);
`endif
    Reset = 1'b1;
    cpu_op(1'b1, 32'h30, 32'hCAFE_F00D);
    cpu_op(1'b0, 32'h30, 32'h0);
    cpu_op(1'b0, 32'h10, 32'h0);
    dma_op(1'b1, 32'h40, 32'h0000_0055);
    dma_op(1'b1, 32'h44, 32'h0000_0066);
`ifdef DM_ARB_STATS_EN
    check("stats_stall_cnt", {16'b0, stall_cnt}, 32'd3);
    check("stats_dma_cnt", {16'b0, dma_cnt}, 32'd2);
`endif
    dma_op(1'b0, 32'h44, 32'h0);
    cpu_op(1'b0, 32'h40, 32'h0);

    repeat (2) @(posedge CLK);
    check("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
    check("dma_queue_drained", 32'(dma_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
